// File: rtl/tea_pkg.sv
// Shared constants, FSM state type and key-schedule helper for the iterative TEA core.
// Every TEA file imports this package.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9e37_79b9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns delta*n truncated to 32 bits.
    // Used to seed the decrypt sum with the value encryption ends on.
    function automatic logic [31:0] delta_mul(input int unsigned n,
                                              input logic [31:0] delta = TEA_DELTA);
        logic [63:0] prod;
        prod = 64'(delta) * 64'(n);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/tea_round_cell.sv
// One combinational TEA round, either direction. The core chains several of these
// to evaluate more than one round per clock.
module tea_round_cell
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = TEA_DELTA
) (
    input  logic         encrypt,
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [31:0]  sum,
    input  logic [127:0] key,
    output logic [31:0]  v0_next,
    output logic [31:0]  v1_next,
    output logic [31:0]  sum_next
);

    function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    logic [31:0] k0, k1, k2, k3;
    assign k0 = key[31:0];
    assign k1 = key[63:32];
    assign k2 = key[95:64];
    assign k3 = key[127:96];

    // Decrypt undoes the two half-rounds in reverse order.
    // Each half-round reads the other half's freshly updated value.
    always_comb begin
        // NOTE: combinational outputs get a default first, so no path can infer a latch.
        v0_next  = v0;
        v1_next  = v1;
        sum_next = sum;
        if (encrypt) begin
            v0_next  = v0 + mix(v1, sum, k0, k1);
            v1_next  = v1 + mix(v0_next, sum, k2, k3);
            sum_next = sum + DELTA;
        end else begin
            v1_next  = v1 - mix(v0, sum, k2, k3);
            v0_next  = v0 - mix(v1_next, sum, k0, k1);
            sum_next = sum - DELTA;
        end
    end

endmodule

// File: rtl/tea_iterative_core.sv
// Folded TEA engine: accepts one 64-bit block, applies RPC rounds per enabled cycle,
// and presents the result until downstream takes it.
module tea_iterative_core
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter int          RPC    = 1,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         encrypt,
    input  logic [63:0]  inBlock64,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  outBlock64
);

    localparam int STEPS = ROUNDS / RPC;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [31:0] DEC_SUM0 = delta_mul(ROUNDS, DELTA);

    if (ROUNDS < 2 || ROUNDS > 64 || (ROUNDS % 2) != 0 || RPC < 1 || (ROUNDS % RPC) != 0) begin : g_bad_cfg
        $error("tea_iterative_core: ROUNDS must be even in 2..64 and divisible by RPC");
    end

    state_t           state;
    logic [31:0]      v0_q, v1_q, sum_q;
    logic [127:0]     key_q;
    logic             mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      out_q;

    // Each stage feeds the next through the stage-local signals.
    for (genvar i = 0; i < RPC; i++) begin : g_round
        logic [31:0] v0_i, v1_i, sum_i;
        logic [31:0] v0_o, v1_o, sum_o;

        if (i == 0) begin : g_head
            assign v0_i  = v0_q;
            assign v1_i  = v1_q;
            assign sum_i = sum_q;
        end else begin : g_link
            assign v0_i  = g_round[i-1].v0_o;
            assign v1_i  = g_round[i-1].v1_o;
            assign sum_i = g_round[i-1].sum_o;
        end

        tea_round_cell #(.DELTA(DELTA)) u_cell (
            .encrypt  (mode_q),
            .v0       (v0_i),
            .v1       (v1_i),
            .sum      (sum_i),
            .key      (key_q),
            .v0_next  (v0_o),
            .v1_next  (v1_o),
            .sum_next (sum_o)
        );
    end

    logic [31:0] v0_step, v1_step, sum_step;
    assign v0_step  = g_round[RPC-1].v0_o;
    assign v1_step  = g_round[RPC-1].v1_o;
    assign sum_step = g_round[RPC-1].sum_o;

    // Gating with ena blocks a handshake on a stalled cycle.
    assign in_ready   = ena && (state == IDLE);
    assign out_valid  = ena && (state == DONE);
    assign outBlock64 = out_q;

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments, so all of them
        // see the values from before the edge.
        if (!rst) begin
            state  <= IDLE;
            v0_q   <= '0;
            v1_q   <= '0;
            sum_q  <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        v0_q   <= inBlock64[31:0];
                        v1_q   <= inBlock64[63:32];
                        key_q  <= key;
                        mode_q <= encrypt;
                        sum_q  <= encrypt ? DELTA : DEC_SUM0;
                        cnt_q  <= CNT_LOAD;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    v0_q  <= v0_step;
                    v1_q  <= v1_step;
                    sum_q <= sum_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        out_q <= {v1_step, v0_step};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_iterative_core.sv
// Scoreboard bench for tea_iterative_core: a driver pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_tea_iterative_core;
    import tea_pkg::*;

    localparam int ROUNDS = 32;
    localparam logic [63:0] ZERO_CT = 64'h94baa940_41ea3a0a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         encrypt = 1'b0;
    logic         out_ready = 1'b1;
    logic [63:0]  in_block = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid;
    logic [63:0]  out_block;

    logic         in4_valid = 1'b0;
    logic         enc4 = 1'b1;
    logic         ena4 = 1'b1;
    logic         out4_ready = 1'b1;
    logic [63:0]  in4_block = '0;
    logic [127:0] key4 = '0;
    logic         in4_ready, out4_valid;
    logic [63:0]  out4_block;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [63:0] blk;
        time         t_acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    bit   rand_bp  = 1'b0;
    logic or_force = 1'b1;

    tea_iterative_core #(.ROUNDS(ROUNDS), .RPC(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .encrypt(encrypt), .inBlock64(in_block), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .outBlock64(out_block)
    );

    tea_iterative_core #(.ROUNDS(ROUNDS), .RPC(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena4), .in_valid(in4_valid), .in_ready(in4_ready),
        .encrypt(enc4), .inBlock64(in4_block), .key(key4), .out_valid(out4_valid),
        .out_ready(out4_ready), .outBlock64(out4_block)
    );

    always #5 clk = ~clk;

    // out_ready changes just after the rising edge so the monitor's view is unambiguous.
    always @(posedge clk) begin
        #1 out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook TEA: sum is advanced before use when encrypting.
    function automatic logic [63:0] tea_ref(input logic [63:0] b, input logic [127:0] k, input bit enc);
        logic [31:0] y, z, s;
        y = b[31:0];
        z = b[63:32];
        if (enc) begin
            s = 32'd0;
            for (int r = 0; r < ROUNDS; r++) begin
                s = s + TEA_DELTA;
                y = y + (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
                z = z + (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
            end
        end else begin
            s = TEA_DELTA * 32'(ROUNDS);
            for (int r = 0; r < ROUNDS; r++) begin
                z = z - (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
                y = y - (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
                s = s - TEA_DELTA;
            end
        end
        return {z, y};
    endfunction

    // Monitor: latency on the rising edge of out_valid, result on handshake,
    // and a stable result while held off.
    logic        prev_valid = 1'b0;
    logic        hold_chk = 1'b0;
    logic [63:0] held = '0;
    always @(negedge clk) begin
        longint lat;
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                lat = longint'(($time - sb[0].t_acc - 5) / 10);
                check("latency", 64'(lat), 64'(sb[0].lat));
            end
        end
        if (out_valid && prev_valid && hold_chk) check("hold_stable", out_block, held);
        held     = out_block;
        hold_chk = out_valid && !out_ready;
        if (out_valid && out_ready && sb.size() != 0) begin
            check("result", out_block, sb[0].blk);
            void'(sb.pop_front());
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [63:0] b, input logic [127:0] k, input bit enc,
                        input logic [63:0] exp, input int lat);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_block = b;
        key      = k;
        encrypt  = enc;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{blk: exp, t_acc: $time, lat: lat});
        @(negedge clk);
        // Scramble the inputs so any late sampling would corrupt the result.
        in_valid = 1'b0;
        in_block = {$urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
        encrypt  = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    task automatic test_rpc4();
        time t;
        int  w = 0;
        @(negedge clk);
        in4_valid = 1'b1;
        in4_block = '0;
        key4      = '0;
        enc4      = 1'b1;
        check("rpc4_in_ready", 64'(in4_ready), 64'(1));
        @(posedge clk);
        t = $time;
        @(negedge clk);
        in4_valid = 1'b0;
        in4_block = {$urandom, $urandom};
        while (!out4_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rpc4_latency", 64'(($time - t - 5) / 10), 64'(8));
        check("rpc4_result", out4_block, ZERO_CT);
    endtask

    initial begin
        logic [63:0]  b, c;
        logic [127:0] k;
        int           w;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_block", out_block, 64'(0));
        check("rst4_out_valid", 64'(out4_valid), 64'(0));
        rst = 1'b1;

        // Known zero-key / zero-block vector, both directions.
        send(64'(0), 128'(0), 1'b1, ZERO_CT, 32);
        drain();
        send(ZERO_CT, 128'(0), 1'b0, 64'(0), 32);
        drain();

        test_rpc4();

        // Backpressure: hold out_ready low for 10 cycles in DONE.
        or_force = 1'b0;
        b = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(b, k, 1'b1, tea_ref(b, k, 1'b1), 32);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        or_force = 1'b1;
        repeat (2) @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'(1));
        check("release_out_valid", 64'(out_valid), 64'(0));
        drain();

        // Five stalled cycles mid-BUSY stretch the latency to 37.
        b = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(b, k, 1'b1, tea_ref(b, k, 1'b1), 37);
        repeat (9) @(negedge clk);
        ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        ena = 1'b1;
        drain();

        // Reset at the tenth BUSY cycle discards the block.
        b = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(b, k, 1'b1, tea_ref(b, k, 1'b1), 32);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_block", out_block, 64'(0));
        sb.delete();
        b = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(b, k, 1'b1, tea_ref(b, k, 1'b1), 32);
        drain();

        // Random round trips under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            c = tea_ref(b, k, 1'b1);
            send(b, k, 1'b1, c, 32);
            send(c, k, 1'b0, b, 32);
        end
        drain();
        rand_bp = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
